// File: rtl/morse_tx_scheduler_if.sv
// Character push handshake into the Morse scheduler.
// master drives sym_valid/code_bits/code_len; slave returns sym_ready.
`timescale 1ns/1ps
interface morse_tx_scheduler_if;
  logic       sym_valid;
  logic       sym_ready;
  logic [4:0] code_bits;
  logic [2:0] code_len;

  modport master (
    output sym_valid,
    output code_bits,
    output code_len,
    input  sym_ready
  );

  modport slave (
    input  sym_valid,
    input  code_bits,
    input  code_len,
    output sym_ready
  );
endinterface

// File: rtl/morse_tx_scheduler.sv
// Morse playback: FIFO of coded chars, unit-timed marks/gaps on tone.
// Ports: clk, rst(async low), en, flush, sym_if(push), tone, busy, sym_done, fifo_count, fifo_full.
`timescale 1ns/1ps
module morse_tx_scheduler #(
  parameter int DEPTH       = 8,
  parameter int UNIT_CYCLES = 12500000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     flush,
  morse_tx_scheduler_if.slave      sym_if,
  output logic                     tone,
  output logic                     busy,
  output logic                     sym_done,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     fifo_full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = $clog2(UNIT_CYCLES);
  localparam logic [DW-1:0] DIV_LAST = DW'(UNIT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, MARK, EGAP, CGAP, WSPACE
  } state_e;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  state_e        state_q, state_d;
  logic [4:0]    sh_q, sh_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [2:0]    units_q, units_d;
  logic [DW-1:0] div_q, div_d;
  logic          tone_q, tone_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic       full, empty, push, pop;
  logic       timed, tick, last;
  logic [7:0] head;
  logic [2:0] len_in;

  always_comb begin
    full   = count_q == CW'(DEPTH);
    empty  = count_q == '0;
    push   = sym_if.sym_valid && !full;
    pop    = (state_q == IDLE) && en && !empty && !flush;
    timed  = state_q inside {MARK, EGAP, CGAP, WSPACE};
    tick   = timed && (div_q == DIV_LAST);
    last   = tick && (units_q == 3'd1);
    head   = mem[rd_ptr_q];
    len_in = (head[2:0] > 3'd5) ? 3'd5 : head[2:0];

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case (1'b1)
        push && !pop: count_d = count_q + 1'b1;
        pop && !push: count_d = count_q - 1'b1;
        default:      count_d = count_q;
      endcase
    end

    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    units_d = units_q;
    done_d  = 1'b0;
    if (tick && !last) units_d = units_q - 3'd1;

    // Dropping en abandons the current char silently.
    if (state_q != IDLE && !en) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (pop) begin
          sh_d    = head[7:3];
          cnt_d   = len_in;
          state_d = LOAD;
        end
        LOAD: if (cnt_q == 3'd0) begin
          state_d = WSPACE;
          units_d = 3'd7;
        end else begin
          state_d = MARK;
          units_d = sh_q[4] ? 3'd3 : 3'd1;
        end
        MARK: if (last) begin
          cnt_d = cnt_q - 3'd1;
          sh_d  = {sh_q[3:0], 1'b0};
          if (cnt_q == 3'd1) begin
            state_d = CGAP;
            units_d = 3'd3;
          end else begin
            state_d = EGAP;
            units_d = 3'd1;
          end
        end
        EGAP: if (last) begin
          state_d = MARK;
          units_d = sh_q[4] ? 3'd3 : 3'd1;
        end
        CGAP, WSPACE: if (last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end

    // Divider restarts on every state entry.
    if (timed && state_d == state_q)
      div_d = tick ? '0 : div_q + 1'b1;
    else
      div_d = '0;

    tone_d = (state_q == MARK) && en;
    busy_d = (state_q != IDLE) && en;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= IDLE;
      sh_q     <= '0;
      cnt_q    <= '0;
      units_q  <= '0;
      div_q    <= '0;
      tone_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      sh_q     <= sh_d;
      cnt_q    <= cnt_d;
      units_q  <= units_d;
      div_q    <= div_d;
      tone_q   <= tone_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush)
      mem[wr_ptr_q] <= {sym_if.code_bits, sym_if.code_len};
  end

  assign sym_if.sym_ready = !full;
  assign tone             = tone_q;
  assign busy             = busy_q;
  assign sym_done         = done_q;
  assign fifo_count       = count_q;
  assign fifo_full        = full;
endmodule

// File: tb/tb_morse_tx_scheduler.sv
// Scoreboard bench for morse_tx_scheduler with a unit-level reference model.
// Stimulus queues expected chars; a negedge monitor checks each sym_done.
`timescale 1ns/1ps
module tb_morse_tx_scheduler;
  localparam int DEPTH = 8;
  localparam int U     = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [2:0] n;
    logic [4:0] dash;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en = 1'b0;
  logic flush = 1'b0;
  logic tone, busy, sym_done, fifo_full;
  logic [CW-1:0] fifo_count;

  int total = 0;
  int bad = 0;
  exp_t exp_q[$];

  morse_tx_scheduler_if sif();

  morse_tx_scheduler #(
    .DEPTH(DEPTH),
    .UNIT_CYCLES(U)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .flush(flush),
    .sym_if(sif.slave),
    .tone(tone),
    .busy(busy),
    .sym_done(sym_done),
    .fifo_count(fifo_count),
    .fifo_full(fifo_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t model(input logic [4:0] b, input logic [2:0] l);
    exp_t e;
    e.n = (l > 3'd5) ? 3'd5 : l;
    e.dash = b;
    return e;
  endfunction

  function automatic int mark_len(input exp_t e, input int i);
    return e.dash[4-i] ? 3 * U : U;
  endfunction

  // LOAD cycle plus every mark, inter-element gap and trailing gap.
  function automatic int busy_len(input exp_t e);
    int s;
    if (e.n == 0) return 1 + 7 * U;
    s = 0;
    for (int i = 0; i < int'(e.n); i++) s += e.dash[4-i] ? 3 : 1;
    return 1 + U * (s + int'(e.n) - 1 + 3);
  endfunction

  int mk[$];
  int gp[$];
  int hi_run, lo_run, bcnt;
  logic pt;

  task automatic check_char();
    exp_t e;
    int ng;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_done: got sym_done want none at %0t", $time);
      return;
    end
    e = exp_q.pop_front();
    ng = (e.n == 0) ? 0 : int'(e.n) - 1;
    chk("mark_count", mk.size(), int'(e.n));
    for (int i = 0; i < mk.size() && i < int'(e.n); i++)
      chk("mark_len", mk[i], mark_len(e, i));
    chk("gap_count", gp.size(), ng);
    for (int i = 0; i < gp.size(); i++)
      chk("gap_len", gp[i], U);
    chk("busy_len", bcnt, busy_len(e));
  endtask

  initial begin
    hi_run = 0; lo_run = 0; bcnt = 0; pt = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        mk.delete(); gp.delete();
        hi_run = 0; lo_run = 0; bcnt = 0; pt = 1'b0;
      end else begin
        if (tone) begin
          if (!pt) begin
            if (mk.size() > 0) gp.push_back(lo_run);
            hi_run = 0;
          end
          hi_run++;
        end else begin
          if (pt) begin
            mk.push_back(hi_run);
            lo_run = 0;
          end
          lo_run++;
        end
        pt = tone;
        if (busy) bcnt++;
        if (sym_done) begin
          check_char();
          mk.delete(); gp.delete(); bcnt = 0;
        end else if (!busy) begin
          mk.delete(); gp.delete(); bcnt = 0;
        end
      end
    end
  end

  task automatic push(input logic [4:0] b, input logic [2:0] l, input bit acc);
    @(negedge clk);
    sif.sym_valid = 1'b1;
    sif.code_bits = b;
    sif.code_len  = l;
    chk("sym_ready", int'(sif.sym_ready), int'(acc));
    if (acc) exp_q.push_back(model(b, l));
    @(posedge clk);
    #1;
    sif.sym_valid = 1'b0;
  endtask

  task automatic push_latency(input logic [4:0] b, input logic [2:0] l);
    push(b, l, 1'b1);
    repeat (3) @(negedge clk);
    chk("lat_pre", int'(tone), 0);
    @(negedge clk);
    chk("lat_rise", int'(tone), 1);
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (!(exp_q.size() == 0 && !busy) && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (k >= budget) begin
      total++;
      bad++;
      $display("FAIL idle_timeout: got pending=%0d want 0", exp_q.size());
    end
  endtask

  task automatic wait_rises(input int n, input int budget);
    int k, r;
    logic p;
    k = 0; r = 0; p = tone;
    while (r < n && k < budget) begin
      @(negedge clk);
      if (tone && !p) r++;
      p = tone;
      k++;
    end
    if (r < n) begin
      total++;
      bad++;
      $display("FAIL tone_rise_timeout: got %0d want %0d", r, n);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] b;
    logic [2:0] l;
    int gap;
    sif.sym_valid = 1'b0;
    sif.code_bits = '0;
    sif.code_len  = '0;

    repeat (3) @(negedge clk);
    chk("rst_tone", int'(tone), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(sym_done), 0);
    chk("rst_count", int'(fifo_count), 0);
    chk("rst_full", int'(fifo_full), 0);
    chk("rst_ready", int'(sif.sym_ready), 1);
    rst = 1'b1;

    en = 1'b1;
    push_latency(5'b00000, 3'd1);
    wait_idle(200);
    chk("e_count", int'(fifo_count), 0);
    chk("e_busy", int'(busy), 0);

    push(5'b01000, 3'd2, 1'b1);
    wait_idle(200);

    en = 1'b0;
    for (int i = 0; i < 8; i++)
      push(5'(i * 7 + 3), 3'(i % 5 + 1), 1'b1);
    @(negedge clk);
    chk("full_count", int'(fifo_count), 8);
    chk("full_flag", int'(fifo_full), 1);
    push(5'b10101, 3'd3, 1'b0);
    @(negedge clk);
    chk("drop_count", int'(fifo_count), 8);
    en = 1'b1;
    wait_idle(2000);

    push(5'b00000, 3'd0, 1'b1);
    push(5'b11111, 3'd7, 1'b1);
    wait_idle(400);

    push(5'b01000, 3'd2, 1'b1);
    push(5'b10000, 3'd1, 1'b1);
    wait_rises(2, 200);
    repeat (2) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    chk("drop_tone", int'(tone), 0);
    chk("drop_busy", int'(busy), 0);
    chk("drop_count", int'(fifo_count), 1);
    void'(exp_q.pop_front());
    repeat (5) @(negedge clk);
    chk("drop_idle", int'(busy), 0);
    en = 1'b1;
    wait_idle(200);

    en = 1'b0;
    push(5'b11000, 3'd2, 1'b1);
    push(5'b00100, 3'd3, 1'b1);
    push(5'b10100, 3'd4, 1'b1);
    @(negedge clk);
    chk("pre_flush", int'(fifo_count), 3);
    sif.sym_valid = 1'b1;
    sif.code_bits = 5'b11100;
    sif.code_len  = 3'd3;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    sif.sym_valid = 1'b0;
    @(negedge clk);
    chk("flush_count", int'(fifo_count), 0);
    chk("flush_full", int'(fifo_full), 0);
    exp_q.delete();
    en = 1'b1;
    repeat (6) @(negedge clk);
    chk("flush_idle", int'(busy), 0);

    push(5'b10000, 3'd1, 1'b1);
    push(5'b00000, 3'd1, 1'b1);
    push(5'b00000, 3'd1, 1'b1);
    wait_rises(1, 50);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_tone", int'(tone), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_count", int'(fifo_count), 0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    push_latency(5'b00000, 3'd1);
    wait_idle(200);

    for (int n = 0; n < 40; n++) begin
      int k;
      k = 0;
      while (exp_q.size() >= DEPTH - 1 && k < 2000) begin
        @(negedge clk);
        k++;
      end
      b = 5'($urandom);
      l = ($urandom_range(0, 9) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
      push(b, l, 1'b1);
      gap = $urandom_range(0, 30);
      repeat (gap) @(negedge clk);
    end
    wait_idle(20000);
    chk("end_count", int'(fifo_count), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
